// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: 8N1 frame constants and the
// arbiter state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_OWN  = 1'b1
    } arb_state_t;

    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream request port pair shared by the console (req0) and debug reporter (req1).
// Handshake: a byte moves on a clock edge where reqN_valid && reqN_ready are both high;
// while valid is high and ready low, the requester holds data and last stable.
interface uart_tx_arbiter_if;
    import uart_pkg::*;

    logic                      req0_valid;
    logic [UART_DATA_BITS-1:0] req0_data;
    logic                      req0_last;
    logic                      req0_ready;
    logic                      req1_valid;
    logic [UART_DATA_BITS-1:0] req1_data;
    logic                      req1_last;
    logic                      req1_ready;

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        output req0_ready, req1_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first serializer. Ready when idle and in the last cycle of the stop bit,
// so a byte offered back-to-back starts its start bit with no idle gap.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [UART_DATA_BITS-1:0] in_data,
    output logic                      in_ready,
    output logic                      busy,
    output logic                      txd
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
    localparam logic [3:0]  STOP_IDX = 4'(UART_FRAME_BITS - 1);

    logic [15:0] baud_cnt;
    logic [3:0]  bit_idx;
    logic [8:0]  shift_q;
    logic        busy_q;
    logic        txd_q;
    logic        bit_end;

    assign bit_end  = (baud_cnt == DIV_LAST);
    assign in_ready = !busy_q || ((bit_idx == STOP_IDX) && bit_end);
    assign busy     = busy_q;
    assign txd      = txd_q;

    // bit_idx 0 is the start bit, 1..8 the data bits, 9 the stop bit; the
    // shift register carries the data bits followed by the stop bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 4'd0;
            shift_q  <= 9'h1ff;
            busy_q   <= 1'b0;
            txd_q    <= 1'b1;
        end else if (in_valid && in_ready) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 4'd0;
            shift_q  <= {1'b1, in_data};
            busy_q   <= 1'b1;
            txd_q    <= 1'b0;
        end else if (busy_q) begin
            if (bit_end) begin
                baud_cnt <= 16'd0;
                if (bit_idx == STOP_IDX) begin
                    bit_idx <= 4'd0;
                    busy_q  <= 1'b0;
                    txd_q   <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    txd_q   <= shift_q[0];
                    shift_q <= {1'b1, shift_q[8:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing rs232_dce_txd between two requesters,
// with an idle timeout that revokes a stalled grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_arbiter_if.slave req,
    output logic [1:0]       grant,
    output logic             busy,
    output logic             timeout_evt,
    output logic             rs232_dce_txd,
    output arb_state_t       state_dbg
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    arb_state_t                state, state_n;
    logic                      owner, owner_n;
    logic                      last_owner, last_owner_n;
    logic [15:0]               tmo_cnt, tmo_n;
    logic                      evt_q, evt_n;
    logic                      ser_ready;
    logic                      owner_valid;
    logic                      owner_last;
    logic                      xfer;
    logic [UART_DATA_BITS-1:0] owner_data;

    assign owner_valid = owner ? req.req1_valid : req.req0_valid;
    assign owner_last  = owner ? req.req1_last  : req.req0_last;
    assign owner_data  = owner ? req.req1_data  : req.req0_data;
    assign xfer        = (state == ARB_OWN) && owner_valid && ser_ready;

    assign req.req0_ready = (state == ARB_OWN) && !owner && ser_ready;
    assign req.req1_ready = (state == ARB_OWN) &&  owner && ser_ready;
    assign grant          = (state == ARB_OWN) ? owner_onehot(owner) : 2'b00;
    assign timeout_evt    = evt_q;
    assign state_dbg      = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            tmo_cnt    <= 16'd0;
            evt_q      <= 1'b0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            last_owner <= last_owner_n;
            tmo_cnt    <= tmo_n;
            evt_q      <= evt_n;
        end
    end

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_owner_n = last_owner;
        tmo_n        = tmo_cnt;
        evt_n        = 1'b0;
        case (state)
            ARB_IDLE: begin
                tmo_n = 16'd0;
                if (req.req0_valid || req.req1_valid) begin
                    state_n = ARB_OWN;
                    owner_n = (req.req0_valid && req.req1_valid) ? !last_owner : req.req1_valid;
                end
            end
            ARB_OWN: begin
                // A transfer always outranks the timeout, so a last byte never raises timeout_evt.
                if (xfer) begin
                    tmo_n = 16'd0;
                    if (owner_last) begin
                        state_n      = ARB_IDLE;
                        last_owner_n = owner;
                    end
                end else if (!owner_valid && ser_ready) begin
                    if (tmo_cnt == TMO_LAST) begin
                        state_n      = ARB_IDLE;
                        last_owner_n = owner;
                        evt_n        = 1'b1;
                        tmo_n        = 16'd0;
                    end else begin
                        tmo_n = tmo_cnt + 16'd1;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    uart_tx_serializer #(.CLK_DIV(CLK_DIV)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .in_valid(xfer),
        .in_data (owner_data),
        .in_ready(ser_ready),
        .busy    (busy),
        .txd     (rs232_dce_txd)
    );

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `rs232_dce_txd` UART transmit line between two byte-stream requesters: the CPU console port (requester 0) and the debug/event reporter (requester 1). Grants are round-robin, locked for a whole packet (through the `last` byte), with an idle timeout. An internal 8N1 serializer drives the pin. The block sits between the picorv32 peripheral bus and the chip-level `rs232_dce_txd` output.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `TIMEOUT`, 4096: idle cycles tolerated mid-packet before the grant is revoked; legal range 2..65535.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester has a byte on `reqN_data`.
- `req0_data`, `req1_data`  in  8  byte to transmit.
- `req0_last`, `req1_last`  in  1  byte is the final byte of the packet.
- `req0_ready`, `req1_ready`  out  1  byte accepted this cycle when high with `reqN_valid`.
- `grant`  out  2  one-hot current owner; 2'b00 when idle.
- `busy`  out  1  serializer is mid-frame.
- `timeout_evt`  out  1  one-cycle pulse when a grant is revoked by timeout.
- `rs232_dce_txd`  out  1  serial output; idles high.

## Operation
- Arbiter FSM has two states, IDLE and OWN, plus an `owner` bit and a `last_owner` bit.
- IDLE → OWN:
  - If exactly one `reqN_valid` is high, grant it.
  - If both are high, grant the requester that is not `last_owner`.
  - `grant` becomes valid the cycle after the request is seen.
- In OWN:
  - `reqN_ready` = (N == owner) && serializer ready. It is combinational and never high for the non-owner.
  - A transfer is `valid && ready`. The byte is loaded into the serializer on that edge.
  - A transfer with `last`=1 returns the FSM to IDLE, sets `last_owner` to owner, and clears `grant`.
- Timeout:
  - In OWN, a counter increments each cycle that the owner's valid is low and the serializer is ready.
  - The counter clears on any transfer.
  - When the count reaches TIMEOUT-1, the FSM goes to IDLE, `timeout_evt` pulses for one cycle, and `last_owner` is set to owner.
- Serializer frame format: 8N1, LSB first, one start bit (0), eight data bits, one stop bit (1). Each bit lasts CLK_DIV cycles.
- Serializer ready rule: ready in idle, and also in the final cycle of the stop bit. Back-to-back bytes are therefore gap-free.
- Requesters must hold `data` and `last` stable while `valid` is high and `ready` is low. The arbiter never drops a byte once `valid` is high and the requester owns the grant.
- Simultaneous events: if a `last` transfer and the timeout expiry fall on the same cycle, the transfer wins and no `timeout_evt` is issued.

## Timing
- Reset values:
  - `rs232_dce_txd`=1, `grant`=00, `busy`=0, `timeout_evt`=0, `reqN_ready`=0.
  - `last_owner`=1, so requester 0 wins the first tie.
  - FSM in IDLE; bit counter and timeout counter at 0.
- Reset asserted mid-frame: `rs232_dce_txd` is 1 in the first cycle after the reset edge, and the partial frame is abandoned.
- Request to ready latency: a request seen in IDLE at cycle T gives `grant` and `reqN_ready` high in cycle T+1 (serializer idle).
- Byte accepted at edge E:
  - Start bit drives cycles E+1..E+CLK_DIV.
  - Data bit k drives cycles E+1+(k+1)·CLK_DIV..E+(k+2)·CLK_DIV.
  - Stop bit ends at cycle E+10·CLK_DIV.
  - `busy` is high over E+1..E+10·CLK_DIV.
- Sustained throughput: one byte per 10·CLK_DIV cycles.
- Between packets from different owners there is at least one IDLE cycle on the arbiter. The serializer may still be finishing the stop bit during that cycle, and the line stays correct.

## Structure
- Shared package `uart_pkg`:
  - 8N1 frame constants (`UART_DATA_BITS`=8, `UART_FRAME_BITS`=10).
  - Arbiter state encoding (IDLE=0, OWN=1).
- One sub-module, `uart_tx_serializer`:
  - Parameter `CLK_DIV`.
  - Ports: `clk`, `reset`, `in_valid`, `in_data[7:0]`, `in_ready`, `busy`, `txd`.
  - Contains the baud counter (16-bit), the bit index (4-bit) and a 9-bit shift register.
- Top level holds the FSM, `owner`/`last_owner` and the 16-bit timeout counter.

## Test plan
All scenarios use CLK_DIV=4 and TIMEOUT=16.
1. Reset released, no requests → `rs232_dce_txd`=1 and `grant`=00 for 100 cycles; `busy`=0.
2. req0 sends 0x55 with last=1 → `grant`=01 one cycle after valid. Line shows 0, then 1,0,1,0,1,0,1,0, then 1, each bit 4 cycles wide, 40 cycles total. `grant` returns to 00.
3. Both requesters hold a 2-byte packet from reset → req0 transmits both bytes gap-free (80 cycles), then req1. The next tie after that goes to req0.
4. req1 is granted, sends 1 byte with last=0, then drops valid → `timeout_evt` pulses once, 16 idle cycles after the serializer is ready. `grant`=00, and a pending req0 is granted on the next cycle.
5. Reset asserted 13 cycles into a frame → `rs232_dce_txd`=1 in the next cycle, `grant`=00, and the first tie after reset goes to req0.
6. Owner sends bytes 0xA5, 0x3C with a one-cycle valid gap between them → both frames are correct, no byte is lost or duplicated, and `reqN_ready` is high only while the serializer is ready.
